// File: rtl/audio_sample_feeder_if.sv
// rtl/audio_sample_feeder_if.sv - Avalon-MM register bus bundle for audio_sample_feeder
interface audio_sample_feeder_if;
  logic        avs_chipselect;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_chipselect,
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_chipselect,
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/audio_sample_feeder.sv
// rtl/audio_sample_feeder.sv - CPU-fed sample FIFO that bursts blocks into the ping-pong audio buffer
// Optional underrun cycle counter at register 3: AUDIO_FEEDER_UNDERRUN_CNT_EN
module audio_sample_feeder #(
  parameter int DEPTH      = 256,
  parameter int BLOCK_LEN  = 100,
  parameter int LOW_WM_RST = 100
) (
  input  logic                  rclk,
  input  logic                  reset,
  audio_sample_feeder_if.slave  avs,
  input  logic                  buf_irq,
  output logic [15:0]           sample_out,
  output logic                  burst_active,
  output logic                  cpu_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BLOCK_LEN + 1);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_UCNT   = 2'd3;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     sample_q;
  logic            burst_q;
  logic            irq_q;

  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;

  logic            enable_q;
  logic            irq_en_q;
  logic [8:0]      low_wm_q;
  logic            underrun_q;
  logic            overflow_q;

  logic            sync1_q;
  logic            sync2_q;
  logic            sync3_q;

  logic [31:0]     readdata_q;
  logic [31:0]     readdata_d;
  logic [15:0]     ucnt_rd;

  // Bus decode
  logic wr_en;
  logic rd_en;
  logic push_req;
  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;
  logic in_burst;
  logic underrun_evt;
  logic irq_edge;
  logic low_flag;

  assign wr_en        = avs.avs_chipselect & avs.avs_write;
  assign rd_en        = avs.avs_chipselect & avs.avs_read;
  assign push_req     = wr_en && (avs.avs_address == ADDR_DATA);
  assign fifo_empty   = (level_q == '0);
  assign fifo_full    = (level_q == LW'(DEPTH));
  // A full FIFO drops the write even if a pop happens that cycle; keeps overflow deterministic.
  assign push         = push_req & ~fifo_full;
  assign in_burst     = (state_q == BURST);
  // Pop only what was already stored before this cycle, so a fresh push into empty waits one cycle.
  assign pop          = in_burst & ~fifo_empty;
  assign underrun_evt = in_burst & fifo_empty;
  assign irq_edge     = sync2_q & ~sync3_q;
  assign low_flag     = (32'(level_q) < 32'(low_wm_q));

  // Next FIFO occupancy from the push/pop pair
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Sample storage; no reset so it maps onto RAM, validity is tracked by the pointers
  always_ff @(posedge rclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= avs.avs_writedata[15:0];
    end
  end

  // FIFO pointers and level; reset flushes whatever is queued
  always_ff @(posedge rclk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

  // Bring buf_irq into rclk and keep one extra stage for rising-edge detection
  always_ff @(posedge rclk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= buf_irq;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // CTRL register
  always_ff @(posedge rclk) begin
    if (reset) begin
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      low_wm_q <= 9'(LOW_WM_RST);
    end else if (wr_en && (avs.avs_address == ADDR_CTRL)) begin
      enable_q <= avs.avs_writedata[0];
      irq_en_q <= avs.avs_writedata[1];
      low_wm_q <= avs.avs_writedata[24:16];
    end
  end

  // Sticky error flags; a new event outranks a simultaneous write-1-to-clear
  always_ff @(posedge rclk) begin
    if (reset) begin
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (underrun_evt) begin
        underrun_q <= 1'b1;
      end else if (wr_en && (avs.avs_address == ADDR_STATUS) && avs.avs_writedata[16]) begin
        underrun_q <= 1'b0;
      end
      if (push_req && fifo_full) begin
        overflow_q <= 1'b1;
      end else if (wr_en && (avs.avs_address == ADDR_STATUS) && avs.avs_writedata[17]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Burst sequencer: exactly BLOCK_LEN output cycles per qualified buffer request
  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sample_q <= 16'h0000;
      burst_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          burst_q <= 1'b0;
          if (irq_edge && enable_q) begin
            state_q <= BURST;
            cnt_q   <= '0;
          end
        end
        BURST: begin
          burst_q  <= 1'b1;
          sample_q <= fifo_empty ? 16'h0000 : mem_q[rd_ptr_q];
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(BLOCK_LEN - 1)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          burst_q <= 1'b0;
        end
      endcase
    end
  end

  // Level interrupt, one cycle behind its cause
  always_ff @(posedge rclk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_en_q & (low_flag | underrun_q);
    end
  end

`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  // Saturating count of starved burst cycles; any write to its address clears it first
  always_ff @(posedge rclk) begin
    if (reset) begin
      ucnt_q <= 16'h0000;
    end else if (wr_en && (avs.avs_address == ADDR_UCNT)) begin
      ucnt_q <= 16'h0000;
    end else if (underrun_evt && (ucnt_q != 16'hFFFF)) begin
      ucnt_q <= ucnt_q + 16'h0001;
    end
  end

  assign ucnt_rd = ucnt_q;
`else
  assign ucnt_rd = 16'h0000;
`endif

  // Register read mux
  always_comb begin
    readdata_d = 32'h0000_0000;
    case (avs.avs_address)
      ADDR_STATUS: begin
        readdata_d[LW-1:0] = level_q;
        readdata_d[16]     = underrun_q;
        readdata_d[17]     = overflow_q;
        readdata_d[18]     = low_flag;
      end
      ADDR_CTRL: begin
        readdata_d[0]     = enable_q;
        readdata_d[1]     = irq_en_q;
        readdata_d[24:16] = low_wm_q;
      end
      ADDR_UCNT: begin
        readdata_d[15:0] = ucnt_rd;
      end
      default: readdata_d = 32'h0000_0000;
    endcase
  end

  // Read data is captured one cycle after the strobe and held otherwise
  always_ff @(posedge rclk) begin
    if (reset) begin
      readdata_q <= 32'h0000_0000;
    end else if (rd_en) begin
      readdata_q <= readdata_d;
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign sample_out       = sample_q;
  assign burst_active     = burst_q;
  assign cpu_irq          = irq_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// tb/tb_audio_sample_feeder.sv - randomized self-checking bench for audio_sample_feeder
module tb_audio_sample_feeder;
  logic        rclk = 1'b0;
  logic        reset = 1'b1;
  logic        buf_irq = 1'b0;
  logic [15:0] sample_out;
  logic        burst_active;
  logic        cpu_irq;

  audio_sample_feeder_if bus ();

  audio_sample_feeder #(
    .DEPTH(256),
    .BLOCK_LEN(100),
    .LOW_WM_RST(100)
  ) dut (
    .rclk(rclk),
    .reset(reset),
    .avs(bus),
    .buf_irq(buf_irq),
    .sample_out(sample_out),
    .burst_active(burst_active),
    .cpu_irq(cpu_irq)
  );

  always #5 rclk = ~rclk;

  int passed = 0;
  int total  = 0;

  // Reference model: FIFO contents and register state as the CPU sees them
  logic [15:0] m_fifo [$];
  bit          m_unr;
  bit          m_ovf;
  bit          m_en;
  bit          m_ien;
  int          m_lwm;
  int          m_ucnt;
  int          irq_rises;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s     = 32'(m_fifo.size());
    s[16] = m_unr;
    s[17] = m_ovf;
    s[18] = (m_fifo.size() < m_lwm);
    return s;
  endfunction

  function automatic logic [31:0] m_ctrl();
    return (32'(m_lwm) << 16) | (32'(m_ien) << 1) | 32'(m_en);
  endfunction

  function automatic logic [15:0] m_ucnt_rd();
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    return 16'(m_ucnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic bus_idle();
    bus.avs_chipselect = 1'b0;
    bus.avs_address    = 2'd0;
    bus.avs_read       = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_writedata  = 32'h0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge rclk); #1;
    bus.avs_chipselect = 1'b1;
    bus.avs_write      = 1'b1;
    bus.avs_address    = a;
    bus.avs_writedata  = d;
    @(posedge rclk); #1;
    bus.avs_chipselect = 1'b0;
    bus.avs_write      = 1'b0;
    case (a)
      2'd0: if (m_fifo.size() < 256) m_fifo.push_back(d[15:0]); else m_ovf = 1'b1;
      2'd1: begin
        if (d[16]) m_unr = 1'b0;
        if (d[17]) m_ovf = 1'b0;
      end
      2'd2: begin
        m_en  = d[0];
        m_ien = d[1];
        m_lwm = int'(d[24:16]);
      end
      default: m_ucnt = 0;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge rclk); #1;
    bus.avs_chipselect = 1'b1;
    bus.avs_read       = 1'b1;
    bus.avs_address    = a;
    @(posedge rclk); #1;
    d = bus.avs_readdata;
    bus.avs_chipselect = 1'b0;
    bus.avs_read       = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge rclk); #1;
    reset   = 1'b1;
    buf_irq = 1'b0;
    bus_idle();
    repeat (2) @(posedge rclk);
    #1;
    reset = 1'b0;
    m_fifo.delete();
    m_unr  = 0;
    m_ovf  = 0;
    m_en   = 0;
    m_ien  = 0;
    m_lwm  = 100;
    m_ucnt = 0;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) bus_write(2'd0, 32'($urandom_range(0, 65535)));
  endtask

  // Requests one block and checks every emitted sample against the model.
  // abort_at >= 0 resets the design on that burst cycle instead of finishing.
  task automatic run_burst(input int abort_at, input bit second_edge, output int got);
    bit          started;
    bit          prev_irq;
    logic [15:0] exp;
    got       = 0;
    irq_rises = 0;
    prev_irq  = cpu_irq;
    started   = 0;
    buf_irq   = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge rclk); #1;
      if (k == 2) buf_irq = 1'b0;
      if (burst_active === 1'b1) begin
        started = 1;
        break;
      end
    end
    buf_irq = 1'b0;
    total++;
    if (!started) begin
      $display("FAIL burst_start: burst_active=%b after 20 cycles, required 1", burst_active);
      return;
    end
    passed++;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin
        @(posedge rclk); #1;
      end
      if (i == abort_at) begin
        do_reset();
        return;
      end
      if (second_edge && i == 10) buf_irq = 1'b1;
      if (second_edge && i == 14) buf_irq = 1'b0;
      if (m_fifo.size() > 0) begin
        exp = m_fifo.pop_front();
      end else begin
        exp   = 16'h0000;
        m_unr = 1'b1;
        if (m_ucnt < 65535) m_ucnt++;
      end
      total++;
      if ({burst_active, sample_out} !== {1'b1, exp})
        $display("FAIL burst_sample[%0d]: active=%b sample=%h, required active=1 sample=%h",
                 i, burst_active, sample_out, exp);
      else passed++;
      if (cpu_irq === 1'b1 && prev_irq === 1'b0) irq_rises++;
      prev_irq = cpu_irq;
      got++;
    end
    @(posedge rclk); #1;
    total++;
    if (burst_active !== 1'b0)
      $display("FAIL burst_end: burst_active=%b after %0d cycles, required 0", burst_active, got);
    else passed++;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    total++;
    if ({sample_out, burst_active, cpu_irq} !== 18'h0)
      $display("FAIL reset_outputs: sample=%h active=%b irq=%b, required 0", sample_out, burst_active, cpu_irq);
    else passed++;
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status()) $display("FAIL reset_status: got %h, required %h", rd, m_status());
    else passed++;
    bus_read(2'd2, rd);
    total++;
    if (rd !== m_ctrl()) $display("FAIL reset_ctrl: got %h, required %h", rd, m_ctrl());
    else passed++;
    repeat (3) @(posedge rclk);
    #1;
    total++;
    if (bus.avs_readdata !== m_ctrl()) $display("FAIL readdata_hold: got %h, required %h", bus.avs_readdata, m_ctrl());
    else passed++;
    bus_read(2'd0, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL data_read: got %h, required 0", rd);
    else passed++;
    bus_read(2'd3, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL ucnt_reset: got %h, required 0", rd);
    else passed++;
  endtask

  task automatic test_full_burst();
    logic [31:0] rd;
    int          got;
    do_reset();
    for (int i = 1; i <= 150; i++) bus_write(2'd0, 32'(i));
    bus_write(2'd2, (32'd100 << 16) | 32'd1);
    bus_read(2'd2, rd);
    total++;
    if (rd !== m_ctrl()) $display("FAIL ctrl_write: got %h, required %h", rd, m_ctrl());
    else passed++;
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[8:0] !== 9'd150) $display("FAIL level_150: got %h, required %h", rd, m_status());
    else passed++;
    run_burst(-1, 0, got);
    total++;
    if (sample_out !== 16'h0064) $display("FAIL sample_hold: got %h, required 0064", sample_out);
    else passed++;
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[8:0] !== 9'd50) $display("FAIL level_50: got %h, required %h", rd, m_status());
    else passed++;
  endtask

  task automatic test_underrun();
    logic [31:0] rd;
    int          got;
    do_reset();
    fill_random(40);
    bus_write(2'd2, (32'd100 << 16) | 32'd1);
    run_burst(-1, 0, got);
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[16] !== 1'b1) $display("FAIL underrun_sticky: got %h, required %h", rd, m_status());
    else passed++;
    bus_read(2'd3, rd);
    total++;
    if (rd !== 32'(m_ucnt_rd())) $display("FAIL ucnt_value: got %h, required %h", rd, m_ucnt_rd());
    else passed++;
    total++;
    if (cpu_irq !== 1'b0) $display("FAIL irq_masked: got %b, required 0", cpu_irq);
    else passed++;
    bus_write(2'd1, 32'h0001_0000);
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[16] !== 1'b0) $display("FAIL underrun_clear: got %h, required %h", rd, m_status());
    else passed++;
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, rd);
    total++;
    if (rd !== 32'h0) $display("FAIL ucnt_clear: got %h, required 0", rd);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    int          got;
    do_reset();
    fill_random(256);
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[17] !== 1'b0) $display("FAIL full_status: got %h, required %h", rd, m_status());
    else passed++;
    bus_write(2'd0, 32'h0000_BEEF);
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[17] !== 1'b1 || rd[8:0] !== 9'd256)
      $display("FAIL overflow_status: got %h, required %h", rd, m_status());
    else passed++;
    bus_write(2'd1, 32'h0002_0000);
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status()) $display("FAIL overflow_clear: got %h, required %h", rd, m_status());
    else passed++;
    bus_write(2'd2, 32'd1 | (32'd100 << 16));
    run_burst(-1, 0, got);
  endtask

  task automatic test_push_during_burst();
    logic [31:0] rd;
    int          got;
    do_reset();
    fill_random(150);
    bus_write(2'd2, (32'd100 << 16) | 32'd1);
    fork
      run_burst(-1, 0, got);
      begin
        for (int k = 0; k < 30; k++) begin
          @(posedge rclk); #1;
          if (burst_active === 1'b1) break;
        end
        fill_random(10);
      end
    join
    total++;
    if (got !== 100) $display("FAIL burst_len: got %0d cycles, required 100", got);
    else passed++;
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[8:0] !== 9'd60) $display("FAIL level_after_push: got %h, required %h", rd, m_status());
    else passed++;
    run_burst(-1, 0, got);
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    int          got;
    do_reset();
    fill_random(150);
    bus_write(2'd2, (32'd100 << 16) | 32'd3);
    @(posedge rclk); #1;
    total++;
    if (cpu_irq !== 1'b0) $display("FAIL irq_high_level: got %b, required 0", cpu_irq);
    else passed++;
    run_burst(-1, 0, got);
    total++;
    if (irq_rises !== 1) $display("FAIL irq_rises: got %0d, required 1", irq_rises);
    else passed++;
    total++;
    if (cpu_irq !== 1'b1) $display("FAIL irq_low_level: got %b, required 1", cpu_irq);
    else passed++;
    fill_random(70);
    @(posedge rclk); #1;
    total++;
    if (cpu_irq !== 1'b0) $display("FAIL irq_refill: got %b, required 0", cpu_irq);
    else passed++;
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[8:0] !== 9'd120) $display("FAIL level_120: got %h, required %h", rd, m_status());
    else passed++;
  endtask

  task automatic test_edge_and_reset();
    logic [31:0] rd;
    int          got;
    int          extra;
    do_reset();
    fill_random(150);
    bus_write(2'd2, (32'd100 << 16) | 32'd1);
    run_burst(-1, 1, got);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge rclk); #1;
      if (burst_active === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL second_edge: %0d extra burst cycles, required 0", extra);
    else passed++;
    run_burst(30, 0, got);
    total++;
    if ({sample_out, burst_active, cpu_irq} !== 18'h0)
      $display("FAIL abort_outputs: sample=%h active=%b irq=%b, required 0", sample_out, burst_active, cpu_irq);
    else passed++;
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge rclk); #1;
      if (burst_active === 1'b1) extra++;
    end
    total++;
    if (extra !== 0) $display("FAIL abort_idle: %0d burst cycles after reset, required 0", extra);
    else passed++;
    bus_read(2'd1, rd);
    total++;
    if (rd !== m_status() || rd[8:0] !== 9'd0) $display("FAIL abort_level: got %h, required %h", rd, m_status());
    else passed++;
    bus_read(2'd2, rd);
    total++;
    if (rd !== m_ctrl()) $display("FAIL abort_ctrl: got %h, required %h", rd, m_ctrl());
    else passed++;
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_full_burst();
    test_underrun();
    test_overflow();
    test_push_during_burst();
    test_irq();
    test_edge_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
